truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter SETTLE, default 1, giving the wait cycles between applying a vector and sampling; legal range 0..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, scan request; honoured only in IDLE.
REQ-005 SHALL have port nvars, input, 1; 0 = 3-variable function, 1 = 4-variable function.
REQ-006 SHALL have port expected, input, 16, golden truth table; bit i = expected output for vector i.
REQ-007 SHALL have port f_in, input, 1, output of the combinational function under test.
REQ-008 SHALL have port vec, output, 4, registered test vector (A=vec[3], B=vec[2], C=vec[1], D=vec[0] for 4-var; A=vec[2], B=vec[1], C=vec[0], vec[3]=0 for 3-var).
REQ-009 SHALL have port busy, output, 1, high from the cycle after start is accepted until the DONE cycle inclusive.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port table_out, output, 16, captured truth table.
REQ-012 SHALL have port err_count, output, 5, count of mismatching rows (0..16).
REQ-013 SHALL have port match, output, 1, high when the last completed scan had err_count==0.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, WAIT, SAMPLE, DONE.
REQ-015 IDLE with start=1: latch nvars and expected, clear idx, table_out, err_count and match, go to APPLY.
REQ-016 APPLY: drive vec=idx (3-var: vec[3] forced 0); go to WAIT if SETTLE>0, else SAMPLE.
REQ-017 WAIT: hold vec for exactly SETTLE cycles, then go to SAMPLE.
REQ-018 SAMPLE: write table_out[idx]=f_in; if f_in != latched expected[idx], increment err_count.
REQ-019 SAMPLE with idx==N-1 (N=8 for 3-var, 16 for 4-var): go to DONE; otherwise increment idx and go to APPLY.
REQ-020 DONE: assert done for one cycle, set match=(err_count==0), return to IDLE.
REQ-021 Each vector SHALL take SETTLE+2 cycles; done SHALL be high in cycle N*(SETTLE+2)+1 after the edge that sampled start.
REQ-022 3-var scans SHALL leave table_out[15:8]=0 and SHALL ignore expected[15:8].
REQ-023 start SHALL be ignored in APPLY, WAIT, SAMPLE and DONE; no restart or queuing.
REQ-024 nvars and expected changes during a scan SHALL NOT affect that scan.
REQ-025 table_out, err_count and match SHALL hold their values in IDLE until the next accepted start.
REQ-026 idx SHALL be 4 bits and SHALL NOT wrap past N-1 within a scan.
REQ-027 err_count SHALL saturate logically at 16; it cannot exceed N by construction.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, vec=0, busy=0, done=0, table_out=0, err_count=0, match=0, idx=0, wait counter=0, regardless of clk.
REQ-029 Reset asserted mid-scan SHALL abort the scan with no done pulse; the first start after rst_n rises SHALL run a complete scan.

Verification
REQ-030 SETTLE=1, nvars=0, f_in=~vec[1], expected=0x0033, start pulse -> table_out=0x0033, err_count=0, match=1, done in cycle 25.
REQ-031 nvars=1, f_in=B|(~C&D)|(A&D), expected=0xFAF3 -> table_out=0xFAF2, err_count=1, match=0.
REQ-032 start held high throughout a scan -> exactly one scan and one done pulse; a new scan begins only after IDLE is re-entered.
REQ-033 rst_n pulsed low during vector 5 of a 4-var scan -> all outputs 0 asynchronously, no done; a following start gives a full correct scan.
REQ-034 SETTLE=0, nvars=1 -> no WAIT state; done in cycle 33; vec steps 0..15 every 2 cycles.
REQ-035 Change expected and nvars mid-scan -> results match the values latched at start.

Source files
------------

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - steps a 3/4-variable input vector through a function under test,
// captures its truth table and counts mismatches against a golden table latched at start.
module truth_table_scanner #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        nvars,
    input  logic [15:0] expected,
    input  logic        f_in,
    output logic [3:0]  vec,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  err_count,
    output logic        match
);

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t      state, state_nx;
    logic [3:0]  idx;
    logic [3:0]  idx_inc;
    logic [3:0]  wcnt;
    logic        nv_q;
    logic [15:0] exp_q;
    logic        last_row;

    assign idx_inc  = idx + 4'd1;
    assign last_row = nv_q ? (idx == 4'd15) : (idx == 4'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = APPLY;
            APPLY:   state_nx = (SETTLE > 0) ? WAIT : SAMPLE;
            WAIT:    if (wcnt == WAIT_LAST) state_nx = SAMPLE;
            SAMPLE:  state_nx = last_row ? DONE : APPLY;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so busy/done line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= 16'd0;
            err_count <= 5'd0;
            match     <= 1'b0;
            idx       <= 4'd0;
            wcnt      <= 4'd0;
            nv_q      <= 1'b0;
            exp_q     <= 16'd0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        nv_q      <= nvars;
                        exp_q     <= expected;
                        idx       <= 4'd0;
                        vec       <= 4'd0;
                        wcnt      <= 4'd0;
                        table_out <= 16'd0;
                        err_count <= 5'd0;
                        match     <= 1'b0;
                    end
                end
                APPLY: begin
                    wcnt <= 4'd0;
                end
                WAIT: begin
                    wcnt <= wcnt + 4'd1;
                end
                SAMPLE: begin
                    table_out[idx] <= f_in;
                    if ((f_in != exp_q[idx]) && (err_count != 5'd16)) begin
                        err_count <= err_count + 5'd1;
                    end
                    if (!last_row) begin
                        idx <= idx_inc;
                        vec <= {nv_q & idx_inc[3], idx_inc[2:0]};
                    end
                end
                DONE: begin
                    match <= (err_count == 5'd0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - checks two scanner instances (SETTLE=1 and SETTLE=0) against a
// truth-table reference model, a table of known vectors and reset/start corner cases.
module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        nvars = 1'b0;
    logic [15:0] expected = 16'd0;
    logic        f1, f0;
    logic [3:0]  vec1, vec0;
    logic        busy1, busy0, done1, done0, match1, match0;
    logic [15:0] tbl1, tbl0;
    logic [4:0]  err1, err0;
    int          mode = 0;
    logic [15:0] rnd_tbl = 16'd0;
    int          ncmp = 0;
    int          nbad = 0;

    always #5 clk = ~clk;

    assign f1 = (mode == 0) ? ~vec1[1] :
                (mode == 1) ? (vec1[2] | (~vec1[1] & vec1[0]) | (vec1[3] & vec1[0])) : rnd_tbl[vec1];
    assign f0 = (mode == 0) ? ~vec0[1] :
                (mode == 1) ? (vec0[2] | (~vec0[1] & vec0[0]) | (vec0[3] & vec0[0])) : rnd_tbl[vec0];

    truth_table_scanner #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .nvars(nvars), .expected(expected), .f_in(f1),
        .vec(vec1), .busy(busy1), .done(done1), .table_out(tbl1), .err_count(err1), .match(match1)
    );

    truth_table_scanner #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .nvars(nvars), .expected(expected), .f_in(f0),
        .vec(vec0), .busy(busy0), .done(done0), .table_out(tbl0), .err_count(err0), .match(match0)
    );

    typedef struct {
        logic        nv;
        int          m;
        logic [15:0] ex;
        logic [15:0] tbl;
        int          err;
    } vector_t;

    vector_t tv[5];

    task automatic chk(input string nm, input int act, input int req);
        ncmp++;
        if (act !== req) begin
            nbad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int ref_bit(input int m, input int i, input logic [15:0] rt);
        int a, b, c, d;
        a = (i >> 3) & 1;
        b = (i >> 2) & 1;
        c = (i >> 1) & 1;
        d = i & 1;
        case (m)
            0:       return 1 - c;
            1:       return b | ((1 - c) & d) | (a & d);
            default: return int'(rt[i]);
        endcase
    endfunction

    task automatic model(input logic nv, input logic [15:0] ex, input int m,
                         output logic [15:0] t, output int e);
        int n;
        n = nv ? 16 : 8;
        t = 16'd0;
        e = 0;
        for (int i = 0; i < n; i++) begin
            t[i] = ref_bit(m, i, rnd_tbl) != 0;
            if (t[i] != ex[i]) e++;
        end
    endtask

    task automatic do_scan(input logic nv, input logic [15:0] ex, output int lat1, output int lat0,
                           output bit vok1, output bit vok0);
        int n;
        n = nv ? 16 : 8;
        @(negedge clk);
        start = 1'b1;
        nvars = nv;
        expected = ex;
        @(negedge clk);
        start = 1'b0;
        lat1 = -1;
        lat0 = -1;
        vok1 = 1'b1;
        vok0 = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            if (c <= 3 * n && int'(vec1) != (c - 1) / 3) vok1 = 1'b0;
            if (c <= 2 * n && int'(vec0) != (c - 1) / 2) vok0 = 1'b0;
            if (done1 && lat1 < 0) lat1 = c;
            if (done0 && lat0 < 0) lat0 = c;
            if (lat1 >= 0 && lat0 >= 0) break;
            // Inputs churn mid-scan; results must follow the values latched at start.
            nvars = 1'($urandom);
            expected = 16'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic check_scan(input string nm, input logic nv, input logic [15:0] ex, input int m,
                              input logic [15:0] t, input int e);
        int lat1, lat0, n;
        bit vok1, vok0;
        n = nv ? 16 : 8;
        mode = m;
        do_scan(nv, ex, lat1, lat0, vok1, vok0);
        chk({nm, "_lat_s1"}, lat1, n * 3 + 1);
        chk({nm, "_lat_s0"}, lat0, n * 2 + 1);
        chk({nm, "_tbl_s1"}, int'(tbl1), int'(t));
        chk({nm, "_tbl_s0"}, int'(tbl0), int'(t));
        chk({nm, "_err_s1"}, int'(err1), e);
        chk({nm, "_err_s0"}, int'(err0), e);
        chk({nm, "_vecseq_s1"}, int'(vok1), 1);
        chk({nm, "_vecseq_s0"}, int'(vok0), 1);
        @(negedge clk);
        chk({nm, "_match_s1"}, int'(match1), int'(e == 0));
        chk({nm, "_match_s0"}, int'(match0), int'(e == 0));
        repeat (3) @(negedge clk);
        chk({nm, "_hold_s1"}, int'({busy1, tbl1, err1}), int'({1'b0, t, 5'(e)}));
    endtask

    initial begin
        logic [15:0] t;
        int e, nd, k;
        bit bhi;
        logic nv;
        logic [15:0] ex;

        tv[0] = '{nv: 1'b0, m: 0, ex: 16'h0033, tbl: 16'h0033, err: 0};
        tv[1] = '{nv: 1'b1, m: 1, ex: 16'hFAF3, tbl: 16'hFAF2, err: 1};
        tv[2] = '{nv: 1'b0, m: 1, ex: 16'hFF33, tbl: 16'h00F2, err: 3};
        tv[3] = '{nv: 1'b1, m: 0, ex: 16'h0000, tbl: 16'h3333, err: 8};
        tv[4] = '{nv: 1'b1, m: 0, ex: 16'hCCCC, tbl: 16'h3333, err: 16};

        #1 rst_n = 1'b0;
        #1;
        chk("reset_s1", int'({vec1, busy1, done1, tbl1, err1, match1}), 0);
        chk("reset_s0", int'({vec0, busy0, done0, tbl0, err0, match0}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            check_scan($sformatf("tv%0d", i), tv[i].nv, tv[i].ex, tv[i].m, tv[i].tbl, tv[i].err);
        end

        for (int i = 0; i < 6; i++) begin
            rnd_tbl = 16'($urandom);
            nv = 1'($urandom);
            model(nv, 16'd0, 2, t, e);
            ex = (i % 3 == 0) ? (t | (nv ? 16'h0000 : 16'hAB00)) : 16'($urandom);
            model(nv, ex, 2, t, e);
            check_scan($sformatf("rnd%0d", i), nv, ex, 2, t, e);
        end

        // start held high: one scan, ignored in DONE, accepted again once IDLE.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        nvars = 1'b1;
        expected = 16'hFAF2;
        @(negedge clk);
        nd = 0;
        bhi = 1'b1;
        for (int c = 1; c <= 49; c++) begin
            if (done1) nd++;
            if (!busy1) bhi = 1'b0;
            @(negedge clk);
        end
        chk("held_done_pulses", nd, 1);
        chk("held_busy_high", int'(bhi), 1);
        chk("held_idle_gap", int'(busy1), 0);
        @(negedge clk);
        chk("held_restart", int'(busy1), 1);
        start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset during vector 5 of a 4-variable scan.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        nvars = 1'b1;
        expected = 16'hFAF3;
        @(negedge clk);
        start = 1'b0;
        for (k = 0; k < 100 && vec1 != 4'd5; k++) @(negedge clk);
        chk("midrst_reach_vec5", int'(vec1), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_async_s1", int'({vec1, busy1, done1, tbl1, err1, match1}), 0);
        nd = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (done1 || done0) nd++;
        end
        chk("midrst_no_done", nd, 0);
        check_scan("after_rst", 1'b1, 16'hFAF3, 1, 16'hFAF2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
